cla_pipelined_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the registered-I/O 4-bit CLA wrapper.
- Splits a WIDTH-bit operation into WIDTH/4 lookahead groups, one group per pipeline stage, with carry and group P/G passed stage to stage.
- Uses a valid/ready handshake on both sides, so it can sit directly in the ALU datapath between operand-fetch and writeback registers.

---
 rtl/cla_pipelined_adder_if.sv | 38 +++
 rtl/cla_pipelined_adder.sv | 143 ++++++++++++++
 tb/tb_cla_pipelined_adder.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cla_pipelined_adder_if.sv
// Operand/result handshake bundle for cla_pipelined_adder.
// The sat signal exists only when CLA_PIPE_SATURATE_EN is defined.
interface cla_pipelined_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
`ifdef CLA_PIPE_SATURATE_EN
  logic             sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             P;
  logic             G;
  logic             ovf;

  modport master (
`ifdef CLA_PIPE_SATURATE_EN
    output sat,
`endif
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, P, G, ovf
  );

  modport slave (
`ifdef CLA_PIPE_SATURATE_EN
    input  sat,
`endif
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, P, G, ovf
  );
endinterface

// File: rtl/cla_pipelined_adder.sv
// Pipelined carry-lookahead adder/subtractor, one 4-bit lookahead group per stage.
// Optional signed saturation is enabled by defining CLA_PIPE_SATURATE_EN.
module cla_pipelined_adder #(
  parameter int WIDTH = 16,
  parameter int NGRP  = WIDTH / 4
) (
  input  logic                   clk,
  input  logic                   rst,
  cla_pipelined_adder_if.slave   io
);

  typedef struct packed {
    logic [3:0] s;
    logic       c3;
    logic       c4;
    logic       p;
    logic       g;
  } grp_t;

  function automatic grp_t cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
    logic [3:0] p, g;
    logic [3:0] c;
    grp_t       r;
    p    = x ^ y;
    g    = x & y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    r.g  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    r.p  = &p;
    r.c4 = r.g | (r.p & ci);
    r.c3 = c[3];
    r.s  = p ^ c;
    return r;
  endfunction

  // Stage 0 is the operand register; stage k (1..NGRP) holds results through group k-1.
  logic [NGRP:0]                 vld_pipe_q, vld_pipe_d;
  logic [NGRP-1:0][WIDTH-1:0]    a_q, a_d;
  logic [NGRP-1:0][WIDTH-1:0]    b_q, b_d;
  logic [NGRP:0][WIDTH-1:0]      sum_q, sum_d;
  logic [NGRP:0]                 c_q, c_d;
  logic [NGRP:0]                 pacc_q, pacc_d;
  logic [NGRP:0]                 gacc_q, gacc_d;
  logic                          cmsb_q, cmsb_d;
`ifdef CLA_PIPE_SATURATE_EN
  logic [NGRP-1:0]               sat_q, sat_d;
`endif

  logic stall;
  grp_t grp;

  assign stall = vld_pipe_q[NGRP] & ~io.out_ready;

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    c_d        = c_q;
    pacc_d     = pacc_q;
    gacc_d     = gacc_q;
    cmsb_d     = cmsb_q;
`ifdef CLA_PIPE_SATURATE_EN
    sat_d      = sat_q;
`endif
    grp        = '0;
    if (!stall) begin
      vld_pipe_d = {vld_pipe_q[NGRP-1:0], io.in_valid};
      a_d[0]     = io.a;
      b_d[0]     = io.sub ? ~io.b : io.b;
      c_d[0]     = io.sub | io.c_in;
      sum_d[0]   = '0;
      pacc_d[0]  = 1'b1;
      gacc_d[0]  = 1'b0;
`ifdef CLA_PIPE_SATURATE_EN
      sat_d[0]   = io.sat;
`endif
      // Operand skew: unconsumed nibbles ride along with their stage.
      for (int k = 1; k < NGRP; k++) begin
        a_d[k] = a_q[k-1];
        b_d[k] = b_q[k-1];
`ifdef CLA_PIPE_SATURATE_EN
        sat_d[k] = sat_q[k-1];
`endif
      end
      for (int k = 1; k <= NGRP; k++) begin
        grp                     = cla4(a_q[k-1][4*(k-1) +: 4], b_q[k-1][4*(k-1) +: 4], c_q[k-1]);
        sum_d[k]                = sum_q[k-1];
        sum_d[k][4*(k-1) +: 4]  = grp.s;
        c_d[k]                  = grp.c4;
        pacc_d[k]               = grp.p & pacc_q[k-1];
        gacc_d[k]               = grp.g | (grp.p & gacc_q[k-1]);
      end
      // grp now holds the MSB group, whose c3 is the carry into the word MSB.
      cmsb_d = grp.c3;
`ifdef CLA_PIPE_SATURATE_EN
      if (sat_q[NGRP-1] && (grp.c3 ^ grp.c4))
        sum_d[NGRP] = a_q[NGRP-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      c_q        <= '0;
      pacc_q     <= '0;
      gacc_q     <= '0;
      cmsb_q     <= 1'b0;
`ifdef CLA_PIPE_SATURATE_EN
      sat_q      <= '0;
`endif
    end else begin
      vld_pipe_q <= vld_pipe_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      c_q        <= c_d;
      pacc_q     <= pacc_d;
      gacc_q     <= gacc_d;
      cmsb_q     <= cmsb_d;
`ifdef CLA_PIPE_SATURATE_EN
      sat_q      <= sat_d;
`endif
    end
  end

  // Outputs are forced low while rst is high so nothing stale leaks during reset.
  assign io.in_ready  = ~stall & ~rst;
  assign io.out_valid = vld_pipe_q[NGRP] & ~rst;
  assign io.sum       = rst ? '0 : sum_q[NGRP];
  assign io.c_out     = c_q[NGRP] & ~rst;
  assign io.P         = pacc_q[NGRP] & ~rst;
  assign io.G         = gacc_q[NGRP] & ~rst;
  assign io.ovf       = (cmsb_q ^ c_q[NGRP]) & ~rst;

endmodule

// File: tb/tb_cla_pipelined_adder.sv
// Directed, table-driven bench for cla_pipelined_adder (WIDTH=16).
module tb_cla_pipelined_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cla_pipelined_adder_if #(.WIDTH(16)) bus();
  cla_pipelined_adder #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .io(bus));

`ifdef CLA_PIPE_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        sat;
    logic [15:0] sum;
    logic [15:0] sat_sum;
    logic        cout;
    logic        p;
    logic        g;
    logic        ovf;
  } vec_t;

  vec_t tbl[12];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_sum(input int i);
    return (SAT_EN && tbl[i].sat) ? tbl[i].sat_sum : tbl[i].sum;
  endfunction

  task automatic drive(input int i);
    bus.a    = tbl[i].a;
    bus.b    = tbl[i].b;
    bus.c_in = tbl[i].cin;
    bus.sub  = tbl[i].sub;
`ifdef CLA_PIPE_SATURATE_EN
    bus.sat  = tbl[i].sat;
`endif
  endtask

  task automatic check_out(input int i);
    chk($sformatf("v%0d sum", i),  32'(bus.sum),   32'(exp_sum(i)));
    chk($sformatf("v%0d cout", i), 32'(bus.c_out), 32'(tbl[i].cout));
    chk($sformatf("v%0d P", i),    32'(bus.P),     32'(tbl[i].p));
    chk($sformatf("v%0d G", i),    32'(bus.G),     32'(tbl[i].g));
    chk($sformatf("v%0d ovf", i),  32'(bus.ovf),   32'(tbl[i].ovf));
  endtask

  // One isolated operation: checks the 5-cycle latency and every output field.
  task automatic run_one(input int i);
    int cyc;
    @(posedge clk); #1;
    drive(i);
    bus.in_valid = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      cyc++;
      @(negedge clk);
    end while (!bus.out_valid && cyc < 20);
    chk($sformatf("v%0d latency", i), 32'(cyc), 32'd5);
    check_out(i);
  endtask

  initial begin
    int  sent, got, stall_cnt, cyc, extra;
    bit  acc, seen;

    //          a        b        cin   sub   sat   sum      sat_sum  cout  P     G     ovf
    tbl[0]  = '{16'h1234, 16'h0FCD, 1'b1, 1'b0, 1'b0, 16'h2202, 16'h2202, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{16'h00F0, 16'h0F10, 1'b0, 1'b0, 1'b0, 16'h1000, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0};

    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    drive(0);

    // Reset held 3 cycles with in_valid asserted.
    repeat (3) begin
      @(negedge clk);
      chk("rst out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst sum",       32'(bus.sum),       32'd0);
      chk("rst in_ready",  32'(bus.in_ready),  32'd0);
    end
    @(posedge clk); #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("in_ready after rst", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 12; i++) run_one(i);

    // Back-to-back stream of 8 with a 4-cycle downstream stall after the first result.
    sent = 0; got = 0; stall_cnt = 0; cyc = 0; acc = 1'b0; seen = 1'b0;
    while (got < 8 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (acc) sent++;
      bus.in_valid = (sent < 8);
      if (sent < 8) drive(sent);
      bus.out_ready = (stall_cnt == 0);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        check_out(got);
        got++;
        if (!seen) begin
          seen      = 1'b1;
          stall_cnt = 4;
        end
      end else if (stall_cnt > 0) begin
        chk("bp in_ready",  32'(bus.in_ready),  32'd0);
        chk("bp out_valid", 32'(bus.out_valid), 32'd1);
        chk("bp held sum",  32'(bus.sum),       32'(exp_sum(got)));
        stall_cnt--;
      end
    end
    chk("bp result count", 32'(got), 32'd8);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.out_valid) extra++;
    end
    chk("bp no duplicate", 32'(extra), 32'd0);

    // Reset with three operations in flight.
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      drive(j + 3);
      bus.in_valid = 1'b1;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    extra = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.out_valid) extra++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) extra++;
    end
    chk("no output after mid rst", 32'(extra), 32'd0);
    run_one(4);
    run_one(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
